// File: rtl/filter_response_analyzer.sv
`default_nettype none
// ============================================================================
//  Module   : filter_response_analyzer
//  Function : Watches the output stream of a filter under test. For each
//             measurement it tracks the peak maximum, peak minimum and sample
//             count, detects settling (HOLD identical consecutive samples),
//             and reports a timeout when TIMEOUT samples pass without settling.
//  Revision : 1.0 - initial release
// ============================================================================
module filter_response_analyzer #(
  parameter int W       = 32,
  parameter int IW      = 16,
  parameter int HOLD    = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          din_valid,
  input  logic [W-1:0]  din,
  output logic          busy,
  output logic          done,
  output logic          settled,
  output logic          timeout,
  output logic [IW-1:0] settle_idx,
  output logic [W-1:0]  final_val,
  output logic [W-1:0]  peak_max,
  output logic [W-1:0]  peak_min,
  output logic [IW-1:0] sample_count
);

  localparam logic [IW-1:0] C_HOLD    = IW'(HOLD);
  localparam logic [IW-1:0] C_TIMEOUT = IW'(TIMEOUT);
  localparam logic [IW-1:0] C_ONE     = IW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_settled;
  logic          r_timeout;
  logic [IW-1:0] r_settle_idx;
  logic [W-1:0]  r_final_val;
  logic [W-1:0]  r_peak_max;
  logic [W-1:0]  r_peak_min;
  logic [IW-1:0] r_sample_count;
  logic [W-1:0]  r_prev_val;
  logic [IW-1:0] r_run_len;
  logic [IW-1:0] r_run_start;

  logic          w_first;
  logic          w_match;
  logic [IW-1:0] w_count_next;
  logic [IW-1:0] w_run_len_next;
  logic [IW-1:0] w_run_start_next;
  logic [W-1:0]  w_peak_max_next;
  logic [W-1:0]  w_peak_min_next;
  logic          w_settle_hit;
  logic          w_timeout_hit;

  // Next-value computation for one accepted sample while running
  always_comb begin
    w_first          = (r_sample_count == '0);
    // Equality only counts against the previous valid sample of this measurement
    w_match          = !w_first && (din == r_prev_val);
    w_count_next     = r_sample_count + C_ONE;
    w_run_len_next   = w_match ? (r_run_len + C_ONE) : C_ONE;
    w_run_start_next = w_match ? r_run_start : r_sample_count;
    w_peak_max_next  = (w_first || ($signed(din) > $signed(r_peak_max))) ? din : r_peak_max;
    w_peak_min_next  = (w_first || ($signed(din) < $signed(r_peak_min))) ? din : r_peak_min;
    w_settle_hit     = (w_run_len_next == C_HOLD);
    w_timeout_hit    = (w_count_next == C_TIMEOUT);
  end

  // Measurement state machine and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_settled      <= 1'b0;
      r_timeout      <= 1'b0;
      r_settle_idx   <= '0;
      r_final_val    <= '0;
      r_peak_max     <= '0;
      r_peak_min     <= '0;
      r_sample_count <= '0;
      r_prev_val     <= '0;
      r_run_len      <= '0;
      r_run_start    <= '0;
    end else if (start) begin
      // Start from any state clears results; a coincident sample is dropped
      r_state        <= S_RUN;
      r_busy         <= 1'b1;
      r_done         <= 1'b0;
      r_settled      <= 1'b0;
      r_timeout      <= 1'b0;
      r_settle_idx   <= '0;
      r_final_val    <= '0;
      r_peak_max     <= '0;
      r_peak_min     <= '0;
      r_sample_count <= '0;
      r_prev_val     <= '0;
      r_run_len      <= '0;
      r_run_start    <= '0;
    end else if ((r_state == S_RUN) && din_valid) begin
      r_sample_count <= w_count_next;
      r_peak_max     <= w_peak_max_next;
      r_peak_min     <= w_peak_min_next;
      r_run_len      <= w_run_len_next;
      r_run_start    <= w_run_start_next;
      r_prev_val     <= din;
      // Settling wins over timeout when both land on the same sample
      if (w_settle_hit) begin
        r_state      <= S_DONE;
        r_busy       <= 1'b0;
        r_done       <= 1'b1;
        r_settled    <= 1'b1;
        r_settle_idx <= w_run_start_next;
        r_final_val  <= din;
      end else if (w_timeout_hit) begin
        r_state      <= S_DONE;
        r_busy       <= 1'b0;
        r_done       <= 1'b1;
        r_timeout    <= 1'b1;
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign settled      = r_settled;
  assign timeout      = r_timeout;
  assign settle_idx   = r_settle_idx;
  assign final_val    = r_final_val;
  assign peak_max     = r_peak_max;
  assign peak_min     = r_peak_min;
  assign sample_count = r_sample_count;

endmodule
`default_nettype wire

// File: tb/tb_filter_response_analyzer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_filter_response_analyzer
//  Function : Self-checking bench for filter_response_analyzer. Expected
//             results come from a small behavioural model and travel through
//             a scoreboard queue until the DUT reports completion.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_filter_response_analyzer;

  localparam int W       = 32;
  localparam int IW      = 16;
  localparam int HOLD    = 4;
  localparam int TIMEOUT = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          din_valid;
  logic [W-1:0]  din;
  logic          busy;
  logic          done;
  logic          settled;
  logic          timeout;
  logic [IW-1:0] settle_idx;
  logic [W-1:0]  final_val;
  logic [W-1:0]  peak_max;
  logic [W-1:0]  peak_min;
  logic [IW-1:0] sample_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          settled;
    logic          timeout;
    logic [IW-1:0] settle_idx;
    logic [W-1:0]  final_val;
    logic [W-1:0]  peak_max;
    logic [W-1:0]  peak_min;
    logic [IW-1:0] sample_count;
  } res_t;

  res_t exp_q[$];

  filter_response_analyzer #(
    .W(W), .IW(IW), .HOLD(HOLD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .din_valid(din_valid), .din(din),
    .busy(busy), .done(done), .settled(settled), .timeout(timeout),
    .settle_idx(settle_idx), .final_val(final_val), .peak_max(peak_max),
    .peak_min(peak_min), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  // Observed outputs bundled for comparison
  function automatic res_t snap();
    res_t r;
    r.busy = busy; r.done = done; r.settled = settled; r.timeout = timeout;
    r.settle_idx = settle_idx; r.final_val = final_val;
    r.peak_max = peak_max; r.peak_min = peak_min; r.sample_count = sample_count;
    return r;
  endfunction

  // Reference model: final results of one measurement over a valid-sample stream
  function automatic res_t model(input int s[$]);
    res_t r;
    int cnt, runlen, rstart, prev, mx, mn;
    r = '0; cnt = 0; runlen = 0; rstart = 0; prev = 0; mx = 0; mn = 0;
    r.busy = 1'b1;
    foreach (s[i]) begin
      if (cnt == 0) begin mx = s[i]; mn = s[i]; end
      else begin
        if (s[i] > mx) mx = s[i];
        if (s[i] < mn) mn = s[i];
      end
      if (cnt > 0 && s[i] == prev) runlen++;
      else begin runlen = 1; rstart = cnt; end
      prev = s[i];
      cnt++;
      if (runlen == HOLD) begin
        r.settled = 1'b1; r.settle_idx = IW'(rstart); r.final_val = s[i];
        r.done = 1'b1; r.busy = 1'b0;
        break;
      end
      if (cnt == TIMEOUT) begin
        r.timeout = 1'b1; r.done = 1'b1; r.busy = 1'b0;
        break;
      end
    end
    r.peak_max = mx; r.peak_min = mn; r.sample_count = IW'(cnt);
    return r;
  endfunction

  task automatic start_pulse(input bit with_valid, input int d);
    start = 1'b1; din_valid = with_valid; din = d;
    @(negedge clk);
    start = 1'b0; din_valid = 1'b0;
  endtask

  // Drives the stream; with gap set, an invalid cycle carrying junk follows each sample
  task automatic send(input int s[$], input bit gap);
    foreach (s[i]) begin
      din_valid = 1'b1; din = s[i];
      @(negedge clk);
      if (gap) begin
        din_valid = 1'b0; din = 32'd555;
        @(negedge clk);
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; din_valid = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (snap() !== res_t'(0)) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", snap(), res_t'(0));
    end
    reset = 1'b0;
    din_valid = 1'b1; din = 32'd42;
    @(negedge clk);
    din_valid = 1'b0;
    checks++;
    if (snap() !== res_t'(0)) begin
      errors++; $display("FAIL idle_ignores_din got=%h exp=%h", snap(), res_t'(0));
    end
  endtask

  // Common flow for one measurement: start, stream, wait, compare, hold check
  task automatic test_stream(input string name, input int s[$], input bit gap,
                             input bit coincident);
    res_t got, exp;
    bit   ok;
    exp_q.push_back(model(s));
    start_pulse(coincident, 1000);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s_busy_after_start got=%b exp=1", name, busy);
    end
    send(s, gap);
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL %s_done_wait got=%b exp=1", name, done);
    end
    got = snap();
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s_result got=%h exp=%h", name, got, exp);
    end
    din_valid = 1'b1; din = 32'd9999;
    repeat (3) @(negedge clk);
    din_valid = 1'b0;
    checks++;
    if (snap() !== exp) begin
      errors++; $display("FAIL %s_hold got=%h exp=%h", name, snap(), exp);
    end
  endtask

  task automatic test_step();
    int s[$] = '{-1, 1, 6, 8, 7, 7, 7, 7, 7, 3};
    test_stream("step", s, 1'b0, 1'b0);
  endtask

  task automatic test_impulse();
    int s[$] = '{-1, 2, 5, 2, -1, 0, 0, 0, 0, 6};
    test_stream("impulse", s, 1'b0, 1'b0);
  endtask

  task automatic test_ramp();
    int s[$];
    for (int i = 0; i < 24; i++) s.push_back(i);
    test_stream("ramp", s, 1'b0, 1'b0);
  endtask

  task automatic test_gapped_start();
    int s[$] = '{-1, 1, 6, 8, 7, 7, 7, 7, 7};
    test_stream("gapped", s, 1'b1, 1'b1);
  endtask

  task automatic test_restart();
    int pre[$] = '{-5, 30, -40};
    int s[$]   = '{-1, 2, 5, 2, -1, 0, 0, 0, 0};
    start_pulse(1'b0, 0);
    send(pre, 1'b0);
    checks++;
    if (sample_count !== 16'd3) begin
      errors++; $display("FAIL restart_pre_count got=%0d exp=3", sample_count);
    end
    test_stream("restart", s, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int pre[$] = '{-1, 1, 6, 8};
    start_pulse(1'b0, 0);
    send(pre, 1'b0);
    reset = 1'b1; start = 1'b1; din_valid = 1'b1; din = 32'd7;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    checks++;
    if (snap() !== res_t'(0)) begin
      errors++; $display("FAIL reset_mid_clear got=%h exp=%h", snap(), res_t'(0));
    end
    repeat (4) @(negedge clk);
    din_valid = 1'b0;
    checks++;
    if (snap() !== res_t'(0)) begin
      errors++; $display("FAIL reset_mid_idle got=%h exp=%h", snap(), res_t'(0));
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_impulse();
    test_ramp();
    test_gapped_start();
    test_restart();
    test_reset_mid();
    test_step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
